// File: rtl/fastserial_rx_fifo.sv
// fastserial_rx_fifo
//
// Byte FIFO sitting between the FTDI fast-serial receiver and the
// Avalon-ST bytes-to-packets sink. The receiver emits one-cycle byte
// strobes that cannot be stalled, so every strobe is either stored or
// counted as a drop. Downstream sees a first-word-fall-through
// valid/ready interface whose outputs all come straight from flops.
//
// Ports
//   i_clk           system clock (12 MHz PLL output)
//   i_rst_n         asynchronous active-low reset
//   i_data          received byte
//   i_strobe        byte-valid strobe, one push per high cycle
//   o_data          head byte
//   o_valid         head byte is valid
//   i_ready         downstream ready; pop when o_valid && i_ready
//   o_level         occupancy 0..DEPTH, head byte included
//   o_overflow      sticky drop flag
//   o_drop_count    saturating count of dropped bytes
//   i_clr_overflow  synchronous clear of o_overflow / o_drop_count
module fastserial_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_W-1:0]     i_data,
  input  logic                  i_strobe,
  output logic [DATA_W-1:0]     o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_overflow,
  output logic [7:0]            o_drop_count,
  input  logic                  i_clr_overflow
);

  localparam int                 DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2+1)'(DEPTH);

  // Storage holds every queued byte, including the one mirrored in the
  // output register; the head slot is only released on a pop.
  logic [DATA_W-1:0]     mem [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr_reg, wr_ptr_next;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg, rd_ptr_next;
  logic [DEPTH_LOG2:0]   level_reg, level_next;
  logic [DEPTH_LOG2:0]   level_after_pop;
  logic                  valid_reg, valid_next;
  logic [DATA_W-1:0]     data_reg, data_next;
  logic                  ovf_reg, ovf_next;
  logic [7:0]            drop_cnt_reg, drop_cnt_next;

  logic pop;
  logic push;
  logic drop;
  logic full;

  always_comb begin
    pop  = valid_reg & i_ready;
    full = (level_reg == LEVEL_FULL);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    push = i_strobe & (~full | pop);
    drop = i_strobe & full & ~pop;

    level_after_pop = level_reg - (DEPTH_LOG2+1)'(pop);
    level_next      = level_after_pop + (DEPTH_LOG2+1)'(push);
    rd_ptr_next     = rd_ptr_reg + DEPTH_LOG2'(pop);
    wr_ptr_next     = wr_ptr_reg + DEPTH_LOG2'(push);
    valid_next      = (level_next != '0);

    // Next head: an already-stored byte if one survives the pop, otherwise
    // the byte arriving this cycle (bypass). With nothing left, hold.
    data_next = data_reg;
    if (level_after_pop != '0) begin
      data_next = mem[rd_ptr_next];
    end else if (push) begin
      data_next = i_data;
    end

    // Clear first, then let a simultaneous drop override it.
    ovf_next      = ovf_reg;
    drop_cnt_next = drop_cnt_reg;
    if (i_clr_overflow) begin
      ovf_next      = 1'b0;
      drop_cnt_next = 8'd0;
    end
    if (drop) begin
      ovf_next = 1'b1;
      if (i_clr_overflow) begin
        drop_cnt_next = 8'd1;
      end else if (drop_cnt_reg != 8'hFF) begin
        drop_cnt_next = drop_cnt_reg + 8'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      valid_reg    <= 1'b0;
      data_reg     <= '0;
      ovf_reg      <= 1'b0;
      drop_cnt_reg <= 8'd0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      level_reg    <= level_next;
      valid_reg    <= valid_next;
      data_reg     <= data_next;
      ovf_reg      <= ovf_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= i_data;
    end
  end

  assign o_data       = data_reg;
  assign o_valid      = valid_reg;
  assign o_level      = level_reg;
  assign o_overflow   = ovf_reg;
  assign o_drop_count = drop_cnt_reg;

endmodule

// File: tb/tb_fastserial_rx_fifo.sv
module tb_fastserial_rx_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       strobe;
  logic [7:0] out_data;
  logic       out_valid;
  logic       ready;
  logic [4:0] level;
  logic       overflow;
  logic [7:0] drop_count;
  logic       clr_ovf;

  fastserial_rx_fifo #(.DATA_W(8), .DEPTH_LOG2(4)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_data         (in_data),
    .i_strobe       (strobe),
    .o_data         (out_data),
    .o_valid        (out_valid),
    .i_ready        (ready),
    .o_level        (level),
    .o_overflow     (overflow),
    .o_drop_count   (drop_count),
    .i_clr_overflow (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model: a queue of bytes the FIFO is holding (head = q[0]).
  logic [7:0] q[$];
  logic [7:0] exp_data;
  logic       exp_ovf;
  int         exp_cnt;

  task automatic model_reset();
    q.delete();
    exp_data = 8'h00;
    exp_ovf  = 1'b0;
    exp_cnt  = 0;
  endtask

  // Apply one cycle of inputs, advance the clock, update the model.
  // Returns at posedge+1 with inputs still applied.
  task automatic step(input logic s, input logic [7:0] d, input logic r, input logic c);
    bit m_pop, m_acc, m_drop;
    strobe  = s;
    in_data = d;
    ready   = r;
    clr_ovf = c;
    m_pop  = (q.size() > 0) && r;
    m_acc  = s && ((q.size() < 16) || m_pop);
    m_drop = s && (q.size() == 16) && !m_pop;
    @(posedge clk);
    if (m_pop) void'(q.pop_front());
    if (m_acc) q.push_back(d);
    if (c) begin
      exp_ovf = 1'b0;
      exp_cnt = 0;
    end
    if (m_drop) begin
      exp_ovf = 1'b1;
      if (exp_cnt < 255) exp_cnt = exp_cnt + 1;
    end
    if (q.size() > 0) exp_data = q[0];
    #1;
  endtask

  task automatic idle();
    strobe = 1'b0; in_data = 8'h00; ready = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", out_valid); else passes++;
    checks++; if (out_data !== 8'h00) $display("FAIL reset_data got=%h want=00", out_data); else passes++;
    checks++; if (level !== 5'd0) $display("FAIL reset_level got=%0d want=0", level); else passes++;
    checks++; if (overflow !== 1'b0 || drop_count !== 8'd0)
      $display("FAIL reset_ovf got=%b/%0d want=0/0", overflow, drop_count); else passes++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset: level=%0d valid=%b", level, out_valid);
  endtask

  task automatic test_reset_midstream();
    step(1, 8'h11, 0, 0);
    step(1, 8'h22, 0, 0);
    checks++; if (level !== 5'd2) $display("FAIL mid_prelevel got=%0d want=2", level); else passes++;
    idle();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid got=%b want=0", out_valid); else passes++;
    checks++; if (level !== 5'd0) $display("FAIL mid_rst_level got=%0d want=0", level); else passes++;
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    step(1, 8'h33, 0, 0);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h33)
      $display("FAIL mid_after got=%b/%h want=1/33", out_valid, out_data); else passes++;
    step(0, 8'h00, 1, 0);
    $display("reset_midstream: level=%0d", level);
  endtask

  task automatic test_latency_order();
    checks++; if (out_valid !== 1'b0) $display("FAIL lat_pre got=%b want=0", out_valid); else passes++;
    step(1, 8'hA5, 1, 0);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5)
      $display("FAIL lat_first got=%b/%h want=1/a5", out_valid, out_data); else passes++;
    step(1, 8'h5A, 1, 0);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h5A || level !== 5'd1)
      $display("FAIL lat_second got=%b/%h/%0d want=1/5a/1", out_valid, out_data, level); else passes++;
    step(0, 8'h00, 1, 0);
    checks++; if (out_valid !== 1'b0 || level !== 5'd0)
      $display("FAIL lat_empty got=%b/%0d want=0/0", out_valid, level); else passes++;
    $display("latency_order: done level=%0d", level);
  endtask

  task automatic test_fill_overflow_passthrough();
    for (int i = 0; i < 16; i++) begin
      step(1, 8'(i), 0, 0);
      checks++; if (level !== 5'(i + 1) || out_data !== 8'h00 || out_valid !== 1'b1)
        $display("FAIL fill_%0d got=%0d/%h/%b want=%0d/00/1", i, level, out_data, out_valid, i + 1); else passes++;
    end
    step(1, 8'hEE, 0, 0);
    step(1, 8'hEF, 0, 0);
    checks++; if (overflow !== 1'b1 || drop_count !== 8'd2)
      $display("FAIL ovf_set got=%b/%0d want=1/2", overflow, drop_count); else passes++;
    checks++; if (level !== 5'd16 || out_data !== 8'h00)
      $display("FAIL ovf_hold got=%0d/%h want=16/00", level, out_data); else passes++;
    step(0, 8'h00, 0, 1);
    checks++; if (overflow !== 1'b0 || drop_count !== 8'd0)
      $display("FAIL ovf_clr got=%b/%0d want=0/0", overflow, drop_count); else passes++;
    step(1, 8'h77, 1, 0);
    checks++; if (level !== 5'd16 || overflow !== 1'b0 || out_data !== 8'h01)
      $display("FAIL full_pushpop got=%0d/%b/%h want=16/0/01", level, overflow, out_data); else passes++;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] want;
      want = (i < 15) ? 8'(i + 1) : 8'h77;
      checks++; if (out_valid !== 1'b1 || out_data !== want)
        $display("FAIL drain_%0d got=%b/%h want=1/%h", i, out_valid, out_data, want); else passes++;
      step(0, 8'h00, 1, 0);
    end
    checks++; if (out_valid !== 1'b0 || level !== 5'd0)
      $display("FAIL drain_end got=%b/%0d want=0/0", out_valid, level); else passes++;
    $display("fill_overflow_passthrough: done");
  endtask

  task automatic test_clr_drop_same_cycle();
    for (int i = 0; i < 16; i++) step(1, 8'($urandom), 0, 0);
    step(1, 8'h99, 0, 0);
    step(1, 8'h98, 0, 0);
    step(1, 8'h97, 0, 1);
    checks++; if (overflow !== 1'b1 || drop_count !== 8'd1)
      $display("FAIL clr_drop got=%b/%0d want=1/1", overflow, drop_count); else passes++;
    step(0, 8'h00, 0, 1);
    checks++; if (overflow !== 1'b0 || drop_count !== 8'd0)
      $display("FAIL clr_only got=%b/%0d want=0/0", overflow, drop_count); else passes++;
    for (int i = 0; i < 16; i++) begin
      checks++; if (out_data !== exp_data)
        $display("FAIL clr_drain_%0d got=%h want=%h", i, out_data, exp_data); else passes++;
      step(0, 8'h00, 1, 0);
    end
    $display("clr_drop_same_cycle: level=%0d", level);
  endtask

  task automatic test_random(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      logic s, r, c;
      s = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      c = ($urandom_range(0, 15) == 0);
      step(s, 8'($urandom), r, c);
      checks++;
      if (out_valid !== (q.size() != 0) || level !== 5'(q.size()) ||
          (out_valid && out_data !== exp_data) ||
          overflow !== exp_ovf || drop_count !== 8'(exp_cnt))
        $display("FAIL %s_%0d got=v%b l%0d d%h o%b c%0d want=v%b l%0d d%h o%b c%0d",
                 name, i, out_valid, level, out_data, overflow, drop_count,
                 q.size() != 0, q.size(), exp_data, exp_ovf, exp_cnt);
      else passes++;
    end
    $display("%s: %0d cycles level=%0d", name, n, level);
  endtask

  task automatic test_saturation();
    step(0, 8'h00, 0, 1);
    for (int i = 0; i < 320; i++) step(1, 8'($urandom), 0, 0);
    checks++; if (drop_count !== 8'd255 || overflow !== 1'b1)
      $display("FAIL sat got=%0d/%b want=255/1", drop_count, overflow); else passes++;
    checks++; if (drop_count !== 8'(exp_cnt) || level !== 5'd16)
      $display("FAIL sat_model got=%0d/%0d want=%0d/16", drop_count, level, exp_cnt); else passes++;
    for (int i = 0; i < 16; i++) begin
      checks++; if (out_data !== exp_data)
        $display("FAIL sat_drain_%0d got=%h want=%h", i, out_data, exp_data); else passes++;
      step(0, 8'h00, 1, 0);
    end
    step(0, 8'h00, 0, 1);
    checks++; if (drop_count !== 8'd0 || overflow !== 1'b0 || level !== 5'd0)
      $display("FAIL sat_clr got=%0d/%b/%0d want=0/0/0", drop_count, overflow, level); else passes++;
    $display("saturation: done");
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    test_reset();
    test_reset_midstream();
    test_latency_order();
    test_fill_overflow_passthrough();
    test_clr_drop_same_cycle();
    test_random(40, "wrap");
    test_random(400, "random");
    test_saturation();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fastserial_rx_fifo.md
Name: fastserial_rx_fifo

Overview:
- Byte FIFO between the FTDI fast-serial receiver and the Avalon-ST bytes-to-packets sink.
- Absorbs the receiver's one-cycle byte strobes, which cannot be back-pressured.
- Presents the bytes downstream with a valid/ready handshake.
- Detects and counts bytes lost when the buffer is full.

Parameters:
- DATA_W, 8, byte width.
- DEPTH_LOG2, 4, log2 of storage depth; DEPTH = 16 entries.

Ports:
- i_clk  in  1  system clock (12 MHz PLL output).
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_data  in  DATA_W  received byte from the fast-serial receiver.
- i_strobe  in  1  byte-valid strobe; each high cycle is one push.
- o_data  out  DATA_W  head byte to the downstream sink.
- o_valid  out  1  head byte is valid.
- i_ready  in  1  downstream ready; pop when o_valid && i_ready.
- o_level  out  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
- o_overflow  out  1  sticky; set when a byte is dropped.
- o_drop_count  out  8  saturating count of dropped bytes.
- i_clr_overflow  in  1  synchronous clear of o_overflow and o_drop_count.

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - Read and write pointers and occupancy go to 0.
  - o_valid=0, o_data=0, o_level=0, o_overflow=0, o_drop_count=0.
  - Storage array is not cleared.
- Reset mid-operation discards all contents immediately; no partial handshake completes.
- Mode: first-word-fall-through, all outputs registered.
  - A push into an empty FIFO gives o_valid=1 with o_data=pushed byte on the next rising edge. Latency is exactly 1 cycle.
- While o_valid=1 and i_ready=0, o_data and o_valid hold stable.
- Pop on a cycle where o_valid && i_ready:
  - The read pointer advances.
  - The next edge presents the next byte, or drops o_valid if the FIFO becomes empty.
  - Back-to-back pops sustain one byte per cycle.
- Push acceptance: i_strobe is accepted if level < DEPTH, or if a pop occurs in the same cycle.
- Simultaneous push and pop:
  - Level is unchanged.
  - Ordering is preserved.
  - On the empty-with-no-head case, the pushed byte becomes head next cycle.
  - In the single-entry case, the popped byte leaves and the pushed byte becomes head next cycle, with o_valid staying 1.
- Overflow: i_strobe with level == DEPTH and no pop in the same cycle:
  - The byte is dropped and stored contents are untouched.
  - o_overflow is set on the next edge.
  - o_drop_count increments, saturating at 255.
- i_clr_overflow:
  - Clears o_overflow and o_drop_count on the next edge.
  - If a drop occurs in the same cycle, the drop wins: o_overflow=1, o_drop_count=1.
- Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH.
- Occupancy is tracked separately, DEPTH_LOG2+1 bits, so full and empty are unambiguous.
- o_level reflects occupancy after the edge, including any byte held in the output register.
- No combinational path from i_ready to any output.

Test Plan:
- Reset mid-stream: push 0x11,0x22 with i_ready=0, then pulse i_rst_n low mid-cycle -> o_valid=0 and o_level=0 immediately (asynchronous). After release, a push of 0x33 gives o_data=0x33 one cycle later.
- Latency/order: i_ready=1, push 0xA5 then 0x5A on consecutive cycles -> o_valid rises 1 cycle after the first strobe, o_data=0xA5 then 0x5A on consecutive cycles, o_level returns to 0.
- Back-pressure and fill: i_ready=0, push 0x00..0x0F (16 bytes) -> o_level=16, o_data=0x00 held stable. Then i_ready=1 for 16 cycles -> outputs 0x00..0x0F in order, o_valid=0 afterward.
- Overflow: FIFO full, push 0xEE and 0xEF with i_ready=0 -> both dropped, o_overflow=1, o_drop_count=2, contents still 0x00..0x0F. Pulse i_clr_overflow -> both return to 0.
- Full with simultaneous push/pop: level=16, i_ready=1 and i_strobe with 0x77 in the same cycle -> accepted, o_overflow stays 0, level stays 16, 0x77 emerges last.
- Wrap and saturation: 40 push/pop cycles through the pointer wrap show no corruption. Holding i_strobe high for 300 cycles while full with i_ready=0 -> o_drop_count=255.
